// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve timing, score pulses, win detection and game-over.
// Optional build macro PONG_WIN_BY_TWO_EN requires a two-point lead to win.
module pong_match_ctrl #(
    parameter int WIN_SCORE   = 11,
    parameter int SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_start,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic [1:0] d_inc,
    output logic       d_clr,
    output logic       ball_hold,
    output logic       ball_launch,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        SCORE = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [6:0] SCORE_MAX  = 7'd99;
    localparam logic [6:0] WIN        = 7'(WIN_SCORE);
    localparam logic [7:0] TIMER_LOAD = 8'(SERVE_TICKS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_score_l;
    logic [6:0] r_score_r;
    logic [6:0] w_score_l_nxt;
    logic [6:0] w_score_r_nxt;
    logic [7:0] r_timer;
    logic [7:0] w_timer_nxt;
    logic       r_btn_prev;
    logic       r_btn_blocked;
    logic       w_start_edge;
    logic [1:0] w_d_inc_nxt;
    logic       w_d_clr_nxt;
    logic       w_launch_nxt;
    logic       w_winner_nxt;
    logic       w_win_l;
    logic       w_win_r;

    // A button held through reset stays blocked until it has been seen released.
    assign w_start_edge = btn_start && !r_btn_prev && !r_btn_blocked;

`ifdef PONG_WIN_BY_TWO_EN
    assign w_win_l = (r_score_l == SCORE_MAX) ||
                     ((r_score_l >= WIN) && ({1'b0, r_score_l} >= ({1'b0, r_score_r} + 8'd2)));
    assign w_win_r = (r_score_r == SCORE_MAX) ||
                     ((r_score_r >= WIN) && ({1'b0, r_score_r} >= ({1'b0, r_score_l} + 8'd2)));
`else
    assign w_win_l = (r_score_l == WIN) || (r_score_l == SCORE_MAX);
    assign w_win_r = (r_score_r == WIN) || (r_score_r == SCORE_MAX);
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_score_l_nxt = r_score_l;
        w_score_r_nxt = r_score_r;
        w_timer_nxt   = r_timer;
        w_d_inc_nxt   = 2'b00;
        w_d_clr_nxt   = 1'b0;
        w_launch_nxt  = 1'b0;
        w_winner_nxt  = winner;
        case (r_state)
            IDLE, OVER: begin
                if (w_start_edge) begin
                    w_d_clr_nxt   = 1'b1;
                    w_score_l_nxt = '0;
                    w_score_r_nxt = '0;
                    w_timer_nxt   = TIMER_LOAD;
                    w_state_nxt   = SERVE;
                end
            end
            SERVE: begin
                if (tick) begin
                    if (r_timer == 8'd1) begin
                        w_launch_nxt = 1'b1;
                        w_state_nxt  = PLAY;
                    end else begin
                        w_timer_nxt = r_timer - 8'd1;
                    end
                end
            end
            PLAY: begin
                if (miss_l && miss_r) begin
                    w_timer_nxt = TIMER_LOAD;
                    w_state_nxt = SERVE;
                end else if (miss_r) begin
                    w_score_l_nxt = (r_score_l == SCORE_MAX) ? SCORE_MAX : r_score_l + 7'd1;
                    w_d_inc_nxt   = 2'b01;
                    w_state_nxt   = SCORE;
                end else if (miss_l) begin
                    w_score_r_nxt = (r_score_r == SCORE_MAX) ? SCORE_MAX : r_score_r + 7'd1;
                    w_d_inc_nxt   = 2'b10;
                    w_state_nxt   = SCORE;
                end
            end
            SCORE: begin
                if (w_win_l) begin
                    w_winner_nxt = 1'b0;
                    w_state_nxt  = OVER;
                end else if (w_win_r) begin
                    w_winner_nxt = 1'b1;
                    w_state_nxt  = OVER;
                end else begin
                    w_timer_nxt = TIMER_LOAD;
                    w_state_nxt = SERVE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_timer       <= '0;
            r_btn_prev    <= 1'b0;
            r_btn_blocked <= btn_start;
            d_inc         <= '0;
            d_clr         <= 1'b0;
            ball_hold     <= 1'b1;
            ball_launch   <= 1'b0;
            game_over     <= 1'b0;
            winner        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
            r_timer     <= w_timer_nxt;
            r_btn_prev  <= btn_start;
            if (!btn_start) begin
                r_btn_blocked <= 1'b0;
            end
            d_inc       <= w_d_inc_nxt;
            d_clr       <= w_d_clr_nxt;
            ball_hold   <= (w_state_nxt != PLAY);
            ball_launch <= w_launch_nxt;
            game_over   <= (w_state_nxt == OVER);
            winner      <= w_winner_nxt;
        end
    end

    assign state = r_state;

endmodule
